fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the ID stage and the branch-comparison logic inside it. Holds the PC, issues one-outstanding-request fetches to instruction memory, and loads the IF/ID pipeline register (instruction, PC, PC+4) that the ID stage decodes and feeds to the comparator. Consumes the ID-stage redirect (branch taken or jump) to flush and refetch, and honours the hazard-unit stall through a one-entry holding buffer.

## Interface
- WIDTH, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  ID stage cannot accept; IF/ID register holds
- redirect_valid  input  1  branch taken (comparator flag AND branch op) or jump, one-cycle pulse
- redirect_pc  input  WIDTH  target; bits [1:0] ignored (treated as 0)
- imem_req  output  1  fetch request valid
- imem_addr  output  WIDTH  fetch address, word aligned
- imem_ready  input  1  request accepted this cycle when imem_req=1
- imem_rvalid  input  1  response data valid; at least 1 cycle after acceptance
- imem_rdata  input  WIDTH  fetched instruction
- id_valid  output  1  IF/ID register holds a live instruction
- id_instr  output  WIDTH  instruction to decode
- id_pc  output  WIDTH  address of id_instr
- id_pc_plus4  output  WIDTH  id_pc + 4, modulo 2^WIDTH

## Operation
- States: IDLE, REQ, RESP, HOLD, DROP.
- IDLE: entered only from reset; next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc. imem_ready=1 -> RESP. Address stays stable until accepted.
- RESP: wait for imem_rvalid. On rvalid: if id_valid=0 or stall=0, load IF/ID (id_instr=rdata, id_pc=pc, id_valid=1), pc <= pc+4, -> REQ; else capture rdata/pc into holding buffer, pc <= pc+4, -> HOLD.
- HOLD: buffered instruction waits; when stall=0, buffer moves into IF/ID, -> REQ.
- DROP: one response outstanding for a flushed address; on imem_rvalid discard data, -> REQ (pc already holds the redirect target).
- Stall without a new response: IF/ID holds all fields; when stall=0 and no response loads, id_valid <= 0 (instruction consumed).
- Redirect (priority over stall and over response load): pc <= {redirect_pc[WIDTH-1:2],2'b00}; id_valid <= 0; holding buffer cleared. Next state: REQ if in IDLE/REQ with request not accepted this cycle, or HOLD; DROP if in RESP without rvalid this cycle, or REQ with imem_ready=1 this cycle; REQ if in RESP with rvalid this cycle (response discarded); DROP stays DROP.
- pc increment wraps 32'hFFFF_FFFC -> 0 with no flag.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=4, state IDLE, buffer empty.
- rst deasserted at cycle 0 edge: imem_req=1 with imem_addr=RESET_PC in cycle 1.
- Zero-wait memory (ready same cycle, rvalid next): one instruction every 2 cycles; rvalid in cycle n -> id_valid=1 and new imem_req in cycle n+1.
- Redirect in cycle n -> id_valid=0 in n+1; imem_req with redirect_pc in n+1 unless DROP.
- rst mid-operation overrides everything in the same edge; an outstanding memory response after reset is not expected by the memory model.
- imem_req never deasserts before imem_ready except on redirect or rst.

## Structure
- Shared package rv_pkg: fetch state enum, NOP_INSTR = 32'h0000_0013, default RESET_PC.
- One sub-module natural: fetch_buffer (one-entry instruction/PC holding register with load, drain, clear).

## Test plan
- Reset, zero-wait memory returning 0x00000013 at 0x0,0x4,0x8 -> imem_req in cycle 1, id_valid rises with id_pc 0,4,8 every 2 cycles, id_pc_plus4 = id_pc+4.
- imem_ready held low 3 cycles at addr 0x10 -> imem_addr stays 0x10, imem_req stays 1, no id_valid change.
- stall=1 for 4 cycles while response for 0x8 arrives -> IF/ID keeps pc 0x4, buffer holds 0x8; stall drop -> id_pc=0x8 next cycle, then fetch 0xC.
- redirect_valid with redirect_pc=0x103 while in RESP for 0x20 -> id_valid=0 next cycle, response for 0x20 discarded, next request addr 0x100.
- redirect and stall=1 in same cycle during HOLD -> buffer cleared, id_valid=0, fetch at target next cycle.
- RESET_PC=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst asserted mid-RESP -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// architectural constants.
package rv_pkg;

    typedef enum logic [2:0] {
        IDLE,  // first cycle out of reset, no request yet
        REQ,   // request raised, waiting for memory to accept it
        RESP,  // request accepted, waiting for its response
        HOLD,  // response parked in the holding buffer behind a stall
        DROP   // response outstanding for a flushed address
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port: single outstanding request, valid/ready accept,
// response returned on rvalid at least one cycle after acceptance.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             ready;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    // Fetch side drives the request, memory side answers it.
    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/fetch_buffer.sv
// One-entry holding register for an instruction and its PC that arrived
// while the IF/ID register could not take it.
module fetch_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic             valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc
);

    // Occupancy flag: a flush or a drain empties the entry, a load fills it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            valid <= 1'b0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload capture on load.
    always_ff @(posedge clk) begin
        // NOTE: the payload is deliberately not reset; it is only ever read while valid is set.
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to
// instruction memory and loads the IF/ID register consumed by decode.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    fetch_unit_if.master      imem,
    output logic              id_valid,
    output logic [WIDTH-1:0]  id_instr,
    output logic [WIDTH-1:0]  id_pc,
    output logic [WIDTH-1:0]  id_pc_plus4
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] BOOT_PC    = RESET_PC & ALIGN_MASK;

    fetch_state_e     state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    logic             id_valid_next;
    logic [WIDTH-1:0] id_instr_next, id_pc_next;

    logic             hold_load, hold_drain, hold_clear;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_instr, hold_pc;

    fetch_buffer #(.WIDTH(WIDTH)) u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .drain      (hold_drain),
        .clear      (hold_clear),
        .load_instr (imem.rdata),
        .load_pc    (pc),
        .valid      (hold_valid),
        .instr      (hold_instr),
        .pc         (hold_pc)
    );

    assign imem.req    = (state == REQ);
    assign imem.addr   = pc;
    assign id_pc_plus4 = id_pc + PC_STEP;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= BOOT_PC;
            id_valid <= 1'b0;
            id_instr <= WIDTH'(NOP_INSTR);
            id_pc    <= '0;
        end else begin
            pc       <= pc_next;
            id_valid <= id_valid_next;
            id_instr <= id_instr_next;
            id_pc    <= id_pc_next;
        end
    end

    // Next state, next PC and IF/ID load decisions; a redirect overrides all.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_next    = state;
        pc_next       = pc;
        // An un-stalled decode consumes its instruction this cycle.
        id_valid_next = id_valid & stall;
        id_instr_next = id_instr;
        id_pc_next    = id_pc;
        hold_load     = 1'b0;
        hold_drain    = 1'b0;
        hold_clear    = 1'b0;

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem.ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (imem.rvalid) begin
                    pc_next = pc + PC_STEP;
                    if (!id_valid || !stall) begin
                        id_valid_next = 1'b1;
                        id_instr_next = imem.rdata;
                        id_pc_next    = pc;
                        state_next    = REQ;
                    end else begin
                        // Decode is stalled on a live instruction: park this one.
                        hold_load  = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    id_valid_next = hold_valid;
                    id_instr_next = hold_instr;
                    id_pc_next    = hold_pc;
                    hold_drain    = 1'b1;
                    state_next    = REQ;
                end
            end
            DROP: begin
                if (imem.rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_valid) begin
            pc_next       = redirect_pc & ALIGN_MASK;
            id_valid_next = 1'b0;
            id_instr_next = id_instr;
            id_pc_next    = id_pc;
            hold_load     = 1'b0;
            hold_drain    = 1'b0;
            hold_clear    = 1'b1;
            // A response still owed for the old path must be swallowed in DROP.
            case (state)
                REQ:     state_next = imem.ready  ? DROP : REQ;
                RESP:    state_next = imem.rvalid ? REQ  : DROP;
                DROP:    state_next = imem.rvalid ? REQ  : DROP;
                default: state_next = REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset PC 0 and 0xFFFF_FFF8)
// share one memory timing; a transaction-level model is checked every cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc;

    logic        id_valid1, id_valid2;
    logic [31:0] id_instr1, id_pc1, id_pc_plus41;
    logic [31:0] id_instr2, id_pc2, id_pc_plus42;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.WIDTH(32)) imem1 ();
    fetch_unit_if #(.WIDTH(32)) imem2 ();

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem1),
        .id_valid       (id_valid1),
        .id_instr       (id_instr1),
        .id_pc          (id_pc1),
        .id_pc_plus4    (id_pc_plus41)
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem2),
        .id_valid       (id_valid2),
        .id_instr       (id_instr2),
        .id_pc          (id_pc2),
        .id_pc_plus4    (id_pc_plus42)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          pend;
    int          pend_cnt;
    int          mem_lat;
    logic [31:0] pend_a1, pend_a2;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'h0000_0013;
        return {a[23:0], 8'h13};
    endfunction

    // One cycle of stimulus, applied at the falling edge.
    task automatic tick(input logic r, input logic s, input logic rd,
                        input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        imem1.rvalid = 1'b0;
        imem2.rvalid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem1.rvalid = 1'b1;
                imem2.rvalid = 1'b1;
                imem1.rdata  = mem_word(pend_a1);
                imem2.rdata  = mem_word(pend_a2);
                pend         = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        rst            = r;
        stall          = s;
        redirect_valid = rd;
        redirect_pc    = rp;
        imem1.ready    = rdy;
        imem2.ready    = rdy;
        if (r) begin
            pend = 1'b0;
        end else if (imem1.req && rdy) begin
            pend     = 1'b1;
            pend_cnt = mem_lat;
            pend_a1  = imem1.addr;
            pend_a2  = imem2.addr;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        req;      // request raised this cycle
        logic [31:0] fpc;      // address of the next fetch
        logic        busy;     // accepted request awaiting its data
        logic        discard;  // accepted request whose data is unwanted
        logic        boot;     // first cycle after reset
        logic        held;     // parked instruction present
        logic [31:0] hinstr;
        logic [31:0] hpc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } model_t;

    function automatic model_t step(input model_t m, input logic [31:0] boot_pc,
                                    input logic r, input logic s, input logic rd,
                                    input logic [31:0] rp, input logic rdy,
                                    input logic rv, input logic [31:0] rdata);
        model_t n;
        logic   accepted;
        logic   owed;
        n        = m;
        accepted = m.req && rdy;
        if (r) begin
            n       = '0;
            n.fpc   = boot_pc;
            n.boot  = 1'b1;
            n.instr = 32'h0000_0013;
            return n;
        end
        n.valid = s ? m.valid : 1'b0;
        if (rd) begin
            owed      = accepted || ((m.busy || m.discard) && !rv);
            n.fpc     = {rp[31:2], 2'b00};
            n.valid   = 1'b0;
            n.held    = 1'b0;
            n.boot    = 1'b0;
            n.busy    = 1'b0;
            n.discard = owed;
            n.req     = !owed;
            return n;
        end
        if (m.boot) begin
            n.boot = 1'b0;
            n.req  = 1'b1;
        end else if (accepted) begin
            n.req  = 1'b0;
            n.busy = 1'b1;
        end else if (m.busy && rv) begin
            n.busy = 1'b0;
            n.fpc  = m.fpc + 32'd4;
            if (!m.valid || !s) begin
                n.valid = 1'b1;
                n.instr = rdata;
                n.pc    = m.fpc;
                n.req   = 1'b1;
            end else begin
                n.held   = 1'b1;
                n.hinstr = rdata;
                n.hpc    = m.fpc;
                n.req    = 1'b0;
            end
        end else if (m.held && !s) begin
            n.held  = 1'b0;
            n.valid = 1'b1;
            n.instr = m.hinstr;
            n.pc    = m.hpc;
            n.req   = 1'b1;
        end else if (m.discard && rv) begin
            n.discard = 1'b0;
            n.req     = 1'b1;
        end
        return n;
    endfunction

    task automatic compare_dut(input string tag, input model_t m,
                               input logic req, input logic [31:0] addr, input logic v,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] p4);
        check({tag, ".imem_req"},    {31'd0, req}, {31'd0, m.req});
        check({tag, ".imem_addr"},   addr,         m.fpc);
        check({tag, ".id_valid"},    {31'd0, v},   {31'd0, m.valid});
        check({tag, ".id_instr"},    instr,        m.instr);
        check({tag, ".id_pc"},       pc,           m.pc);
        check({tag, ".id_pc_plus4"}, p4,           m.pc + 32'd4);
    endtask

    model_t      m1, m2;
    logic        c_rst, c_stall, c_rd, c_rdy, c_rv;
    logic [31:0] c_rp, c_rdata1, c_rdata2;

    // Compare process: advance the model on each edge, then check both DUTs.
    always @(posedge clk) begin
        c_rst    = rst;
        c_stall  = stall;
        c_rd     = redirect_valid;
        c_rp     = redirect_pc;
        c_rdy    = imem1.ready;
        c_rv     = imem1.rvalid;
        c_rdata1 = imem1.rdata;
        c_rdata2 = imem2.rdata;
        #1;
        m1 = step(m1, 32'h0000_0000, c_rst, c_stall, c_rd, c_rp, c_rdy, c_rv, c_rdata1);
        m2 = step(m2, 32'hFFFF_FFF8, c_rst, c_stall, c_rd, c_rp, c_rdy, c_rv, c_rdata2);
        compare_dut("u1", m1, imem1.req, imem1.addr, id_valid1, id_instr1, id_pc1, id_pc_plus41);
        compare_dut("u2", m2, imem2.req, imem2.addr, id_valid2, id_instr2, id_pc2, id_pc_plus42);
    end

    task automatic check_reset_values(input string tag);
        check({tag, " u1 req"},   {31'd0, imem1.req}, 32'd0);
        check({tag, " u1 addr"},  imem1.addr,         32'h0000_0000);
        check({tag, " u2 addr"},  imem2.addr,         32'hFFFF_FFF8);
        check({tag, " u1 valid"}, {31'd0, id_valid1}, 32'd0);
        check({tag, " u1 instr"}, id_instr1,          32'h0000_0013);
        check({tag, " u1 pc"},    id_pc1,             32'h0000_0000);
        check({tag, " u1 pc4"},   id_pc_plus41,       32'h0000_0004);
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem1.ready = 1'b0; imem1.rvalid = 1'b0; imem1.rdata = '0;
        imem2.ready = 1'b0; imem2.rvalid = 1'b0; imem2.rdata = '0;
        pend = 1'b0; pend_cnt = 0; mem_lat = 0;

        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);                          // T3: reset state, IDLE
        check_reset_values("reset");
        tick(0, 0, 0, 0, 1);                          // T4: first request
        check("boot u1 addr", imem1.addr, 32'h0000_0000);
        check("boot u1 req", {31'd0, imem1.req}, 32'd1);
        check("boot u2 addr", imem2.addr, 32'hFFFF_FFF8);
        tick(0, 0, 0, 0, 1);                          // T5: response
        tick(0, 0, 0, 0, 1);                          // T6
        check("zw u1 pc0", id_pc1, 32'h0000_0000);
        check("zw u1 instr", id_instr1, 32'h0000_0013);
        check("zw u1 addr4", imem1.addr, 32'h0000_0004);
        check("zw u2 pc", id_pc2, 32'hFFFF_FFF8);
        tick(0, 0, 0, 0, 1);                          // T7
        tick(0, 1, 0, 0, 1);                          // T8: stall begins
        check("zw u1 pc4", id_pc1, 32'h0000_0004);
        check("wrap u2 pc4", id_pc_plus42, 32'h0000_0000);
        check("wrap u2 addr", imem2.addr, 32'h0000_0000);
        tick(0, 1, 0, 0, 1);                          // T9: response for 0x8 arrives
        tick(0, 1, 0, 0, 1);                          // T10: parked
        check("stall u1 pc", id_pc1, 32'h0000_0004);
        check("stall u1 req", {31'd0, imem1.req}, 32'd0);
        tick(0, 1, 0, 0, 1);                          // T11
        tick(0, 0, 0, 0, 1);                          // T12: stall released
        check("stall u1 valid", {31'd0, id_valid1}, 32'd1);
        tick(0, 0, 0, 0, 1);                          // T13
        check("drain u1 pc8", id_pc1, 32'h0000_0008);
        check("drain u1 addrC", imem1.addr, 32'h0000_000C);
        check("drain u2 pc0", id_pc2, 32'h0000_0000);
        tick(0, 0, 0, 0, 1);                          // T14
        tick(0, 0, 0, 0, 0);                          // T15: addr 0x10, not ready
        tick(0, 0, 0, 0, 0);                          // T16
        tick(0, 0, 0, 0, 0);                          // T17
        check("wait u1 addr", imem1.addr, 32'h0000_0010);
        check("wait u1 req", {31'd0, imem1.req}, 32'd1);
        check("wait u1 valid", {31'd0, id_valid1}, 32'd0);
        tick(0, 0, 0, 0, 1);                          // T18: accepted
        for (int i = 19; i <= 25; i++) tick(0, 0, 0, 0, 1);
        mem_lat = 2;
        tick(0, 0, 0, 0, 1);                          // T26: request 0x20, slow response
        check("slow u1 addr", imem1.addr, 32'h0000_0020);
        tick(0, 0, 1, 32'h0000_0103, 1);              // T27: redirect in RESP
        tick(0, 0, 0, 0, 1);                          // T28
        check("flush u1 valid", {31'd0, id_valid1}, 32'd0);
        check("flush u1 req", {31'd0, imem1.req}, 32'd0);
        tick(0, 0, 0, 0, 1);                          // T29: stale response dropped
        mem_lat = 0;
        tick(0, 0, 0, 0, 1);                          // T30
        check("redir u1 addr", imem1.addr, 32'h0000_0100);
        check("redir u1 req", {31'd0, imem1.req}, 32'd1);
        tick(0, 0, 0, 0, 1);                          // T31
        tick(0, 1, 0, 0, 1);                          // T32
        tick(0, 1, 0, 0, 1);                          // T33: parked
        tick(0, 1, 1, 32'h0000_0200, 1);              // T34: redirect + stall in HOLD
        tick(0, 1, 0, 0, 1);                          // T35
        check("hold u1 valid", {31'd0, id_valid1}, 32'd0);
        check("hold u1 addr", imem1.addr, 32'h0000_0200);
        check("hold u1 req", {31'd0, imem1.req}, 32'd1);
        tick(1, 0, 0, 0, 1);                          // T36: reset while in RESP
        tick(0, 0, 0, 0, 1);                          // T37
        check_reset_values("midreset");
        tick(0, 0, 1, 32'h0000_0300, 1);              // T38: redirect as request accepted
        tick(0, 0, 0, 0, 1);                          // T39
        check("drop u1 req", {31'd0, imem1.req}, 32'd0);
        tick(0, 0, 0, 0, 1);                          // T40
        check("drop u1 addr", imem1.addr, 32'h0000_0300);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
